// File: rtl/cpm_rdo.sv
// cpm_rdo: snapshot readout of NUM_CNT live event counters.
// A Snap captures every counter into a shadow register. The shadow is then
// streamed out one counter per beat over a valid/ready handshake.
// Snap requests that arrive while a stream is in progress are rejected and
// counted in a saturating DropCnt.
// IW must equal clog2(NUM_CNT) so that every index value addresses a counter.
module cpm_rdo #(
  parameter int NUM_CNT = 4,
  parameter int DW      = 8,
  parameter int IW      = 2
) (
  input  logic                  Clk,
  input  logic                  Rstn,
  input  logic                  Snap,
  input  logic [NUM_CNT*DW-1:0] CntIn,
  output logic                  OutVld,
  input  logic                  OutRdy,
  output logic [DW-1:0]         OutDat,
  output logic [IW-1:0]         OutIdx,
  output logic                  OutLast,
  output logic                  Busy,
  output logic [DW-1:0]         DropCnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CNT - 1);

  state_t                     state_q, state_d;
  logic [NUM_CNT-1:0][DW-1:0] shadow_q, shadow_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [DW-1:0]              drop_q, drop_d;

  logic busy;
  logic xfer;
  logic at_last;

  assign busy    = (state_q == SEND);
  assign xfer    = busy && OutRdy;
  assign at_last = (idx_q == LAST_IDX);

  // Next-state logic: capture on Snap, advance on transfer, count rejected Snaps.
  // A Snap that coincides with the final transfer is accepted, so that
  // back-to-back snapshots stream without an idle cycle between them.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (Snap) begin
          shadow_d = CntIn;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          idx_d = '0;
          if (Snap) begin
            shadow_d = CntIn;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IW'(1);
          end
          if (Snap && (drop_q != {DW{1'b1}})) begin
            drop_d = drop_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow, index and drop counter flops; reset abandons any stream.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      drop_q   <= drop_d;
    end
  end

  // Outputs come straight from the flops, so OutVld never depends on OutRdy.
  always_comb begin
    OutVld  = busy;
    Busy    = busy;
    OutIdx  = idx_q;
    OutDat  = busy ? shadow_q[idx_q] : '0;
    OutLast = busy && at_last;
    DropCnt = drop_q;
  end

endmodule

// File: tb/tb_cpm_rdo.sv
// tb_cpm_rdo: scoreboard bench for cpm_rdo.
// The reference model tracks only "beats still owed" and a saturating drop
// count; accepted snapshots push their expected beats into a queue that the
// monitor checks against the DUT on every valid cycle.
module tb_cpm_rdo;

  localparam int NUM_CNT = 4;
  localparam int DW      = 8;
  localparam int IW      = 2;
  localparam int DROP_MAX = (1 << DW) - 1;

  typedef struct {
    logic [DW-1:0] dat;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic                  Clk;
  logic                  Rstn;
  logic                  Snap;
  logic [NUM_CNT*DW-1:0] CntIn;
  logic                  OutVld;
  logic                  OutRdy;
  logic [DW-1:0]         OutDat;
  logic [IW-1:0]         OutIdx;
  logic                  OutLast;
  logic                  Busy;
  logic [DW-1:0]         DropCnt;

  beat_t exp_q[$];
  int    pending;
  int    model_drop;
  int    n_compared;
  int    n_mismatched;

  cpm_rdo #(.NUM_CNT(NUM_CNT), .DW(DW), .IW(IW)) dut (
    .Clk     (Clk),
    .Rstn    (Rstn),
    .Snap    (Snap),
    .CntIn   (CntIn),
    .OutVld  (OutVld),
    .OutRdy  (OutRdy),
    .OutDat  (OutDat),
    .OutIdx  (OutIdx),
    .OutLast (OutLast),
    .Busy    (Busy),
    .DropCnt (DropCnt)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic snap, input logic rdy, input logic [NUM_CNT*DW-1:0] cnt);
    Snap   = snap;
    OutRdy = rdy;
    CntIn  = cnt;
    @(posedge Clk);
    #1;
  endtask

  function automatic void capture(input logic [NUM_CNT*DW-1:0] cnt);
    for (int k = 0; k < NUM_CNT; k++) begin
      beat_t b;
      b.dat  = cnt[k*DW +: DW];
      b.idx  = IW'(k);
      b.last = (k == NUM_CNT - 1);
      exp_q.push_back(b);
    end
    pending = NUM_CNT;
  endfunction

  // Reference model: a snapshot owes NUM_CNT beats; a new one is taken only
  // when nothing is owed or the very last owed beat leaves in this cycle.
  always @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      exp_q.delete();
      pending    = 0;
      model_drop = 0;
    end else begin
      automatic bit streaming = (pending > 0);
      automatic bit moving    = streaming && OutRdy;
      if (!streaming) begin
        if (Snap) capture(CntIn);
      end else if (moving && pending == 1) begin
        if (Snap) capture(CntIn);
        else pending = 0;
      end else begin
        if (moving) pending--;
        if (Snap && model_drop < DROP_MAX) model_drop++;
      end
    end
  end

  // Monitor: compares the presented beat and status away from the clock edge.
  always @(negedge Clk) begin
    if (Rstn) begin
      checkOutput("out_vld", OutVld, pending > 0);
      checkOutput("busy", Busy, pending > 0);
      checkOutput("drop_cnt", DropCnt, model_drop);
      if (pending > 0 && exp_q.size() > 0) begin
        checkOutput("out_dat", OutDat, exp_q[0].dat);
        checkOutput("out_idx", OutIdx, exp_q[0].idx);
        checkOutput("out_last", OutLast, exp_q[0].last);
        if (OutRdy) void'(exp_q.pop_front());
      end else begin
        checkOutput("idle_last", OutLast, 1'b0);
      end
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    pending      = 0;
    model_drop   = 0;
    Rstn   = 1'b0;
    Snap   = 1'b0;
    OutRdy = 1'b0;
    CntIn  = '0;
    #1;
    checkOutput("rst_vld", OutVld, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_idx", OutIdx, 0);
    checkOutput("rst_dat", OutDat, 0);
    checkOutput("rst_last", OutLast, 0);
    checkOutput("rst_drop", DropCnt, 0);
    repeat (2) @(negedge Clk);
    Rstn = 1'b1;
    @(posedge Clk);
    #1;

    $display("[TB] basic stream, always ready");
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    repeat (6) applyStimulus(1'b0, 1'b1, 32'h44332211);

    $display("[TB] stalled stream with CntIn changing after the snap");
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, (i % 3) == 2, 32'hFFFFFFFF);
    repeat (4) applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF);

    $display("[TB] dropped snap mid-stream, then snap on the last beat");
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'hAAAAAAAA);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h88776655);
    repeat (6) applyStimulus(1'b0, 1'b1, 32'h0);

    $display("[TB] drop counter saturation");
    applyStimulus(1'b1, 1'b0, 32'h0D0C0B0A);
    repeat (300) applyStimulus(1'b1, 1'b0, $urandom);
    repeat (6) applyStimulus(1'b0, 1'b1, 32'h0);

    $display("[TB] reset during beat 2");
    applyStimulus(1'b1, 1'b1, 32'h44332211);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("pre_rst_idx", OutIdx, 2);
    Snap = 1'b0;
    Rstn = 1'b0;
    #1;
    checkOutput("mid_rst_vld", OutVld, 0);
    checkOutput("mid_rst_busy", Busy, 0);
    checkOutput("mid_rst_idx", OutIdx, 0);
    checkOutput("mid_rst_dat", OutDat, 0);
    checkOutput("mid_rst_last", OutLast, 0);
    checkOutput("mid_rst_drop", DropCnt, 0);
    @(negedge Clk);
    Rstn = 1'b1;
    @(posedge Clk);
    #1;
    repeat (4) applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    repeat (6) applyStimulus(1'b0, 1'b1, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom % 6) == 0, ($urandom % 4) != 0, $urandom);

    for (int i = 0; i < 100 && pending > 0; i++)
      applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("drain_done", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
